// File: rtl/dmem_arbiter_if.sv
// Bundle shared by the data-RAM arbiter, its two requesters and the RAM.
// The arbiter takes the slave view; requesters and RAM together form the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  logic              aud_req;
  logic [ADDR_W-1:0] aud_addr;
  logic [DATA_W-1:0] aud_rdata;
  logic              aud_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, aud_req, aud_addr, ram_q,
    output cpu_rdata, cpu_ack, cpu_stall, aud_rdata, aud_ack, ram_addr, ram_wdata, ram_wren
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, aud_req, aud_addr, ram_q,
    input  cpu_rdata, cpu_ack, cpu_stall, aud_rdata, aud_ack, ram_addr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and the audio fetcher: 3 cycles req->ack,
// one access per 3 cycles, losers stay pending and the CPU stalls until ack; ARB_ROUND_ROBIN_EN alternates priority.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_AUD = 1'b1;

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt, take, prefer_aud;
  logic              cpu_elig, aud_elig;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cpu_rdata_q, aud_rdata_q;
  logic              cpu_ack_q, aud_ack_q;

  // Masking a port in its own ack cycle keeps a still-held request from re-issuing.
  assign cpu_elig = bus.cpu_req & ~cpu_ack_q;
  assign aud_elig = bus.aud_req & ~aud_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_gnt <= GNT_CPU;
    else if (take) last_gnt <= gnt_nxt;
  end
  assign prefer_aud = (last_gnt == GNT_CPU);
`else
  assign prefer_aud = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_elig || aud_elig) begin
          take      = 1'b1;
          state_nxt = ACC;
          gnt_nxt   = (aud_elig && (!cpu_elig || prefer_aud)) ? GNT_AUD : GNT_CPU;
        end
      end
      ACC:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= GNT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      gnt <= gnt_nxt;
      if (gnt_nxt == GNT_CPU) begin
        addr_q  <= bus.cpu_addr;
        we_q    <= bus.cpu_we;
        wdata_q <= bus.cpu_wdata;
      end else begin
        addr_q <= bus.aud_addr;
        we_q   <= 1'b0;
      end
    end
  end

  // ram_q reflects the address driven during ACC, so it is valid in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack_q   <= 1'b0;
      aud_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aud_rdata_q <= '0;
    end else begin
      cpu_ack_q <= (state == RESP) && (gnt == GNT_CPU);
      aud_ack_q <= (state == RESP) && (gnt == GNT_AUD);
      if ((state == RESP) && !we_q) begin
        if (gnt == GNT_CPU) cpu_rdata_q <= bus.ram_q;
        else                aud_rdata_q <= bus.ram_q;
      end
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_wren  = (state == ACC) && we_q && (gnt == GNT_CPU);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.aud_rdata = aud_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.aud_ack   = aud_ack_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule
